// File: rtl/rv_core_pkg.sv
// Shared core types/constants: data width, NOP encoding, default reset PC and
// the fetch-entry record carried from memory capture to decode.
package rv_core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            exc;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO between instruction memory capture and decode.
// Flush wins over write/read; the head output holds its last value when empty.
module fetch_skid_buffer
  import rv_core_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_en,
  input  logic         i_rd_en,
  input  logic         i_flush,
  input  fetch_entry_t i_wr_data,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  logic [FETCH_ENTRY_W-1:0] r_mem [2];
  fetch_entry_t             r_last;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;
  logic                     w_wr;
  logic                     w_rd;

  assign w_wr = i_wr_en & ~i_flush;
  assign w_rd = i_rd_en & ~i_flush & (r_count != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_last   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // Remember the currently presented head so it stays visible once drained.
      if (r_count != 2'd0) r_last <= fetch_entry_t'(r_mem[r_rd_ptr]);
      if (i_flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_wr) begin
          r_mem[r_wr_ptr] <= i_wr_data;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_rd) r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != 2'd0) ? fetch_entry_t'(r_mem[r_rd_ptr]) : r_last;

  // Issue throttling upstream guarantees a full buffer is never written without a read.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_wr && !w_rd && r_count == 2'd2));

endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch sequencing in front of a 1-cycle synchronous imem.
// Optional FETCH_MISALIGN_CHECK_EN adds IF_EXC and NOP substitution for misaligned PCs.
module instruction_fetch #(
  parameter int               XLEN     = rv_core_pkg::XLEN,  // must match rv_core_pkg::XLEN
  parameter logic [XLEN-1:0]  RESET_PC = rv_core_pkg::DEFAULT_RESET_PC
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            IF_VALID,
  input  logic            ID_READY,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_INSTR
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            IF_EXC
`endif
);

  import rv_core_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_req_valid;
  logic            r_req_exc;
  logic [XLEN-1:0] w_fetch_pc;
  logic [XLEN-1:0] w_store_pc;
  logic            w_fetch_exc;
  logic [1:0]      w_count;
  logic [2:0]      w_occ;
  logic            w_if_valid;
  logic            w_deq;
  logic            w_issue;
  logic            w_wr_en;
  fetch_entry_t    w_wr_entry;
  fetch_entry_t    w_head;

  assign w_fetch_pc = REDIRECT_VALID ? REDIRECT_PC : r_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_store_pc  = w_fetch_pc;
  assign w_fetch_exc = |w_fetch_pc[1:0];
`else
  assign w_store_pc  = {w_fetch_pc[XLEN-1:2], 2'b00};
  assign w_fetch_exc = 1'b0;
`endif

  // A redirect hides the head for its cycle so nothing stale reaches decode.
  assign w_if_valid = (w_count != 2'd0) & ~REDIRECT_VALID;
  assign w_deq      = w_if_valid & ID_READY;
  assign w_occ      = {1'b0, w_count} + {2'b00, r_req_valid} - {2'b00, w_deq};
  assign w_issue    = REDIRECT_VALID | (w_occ < 3'd2);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_req_valid <= 1'b0;
      r_req_exc   <= 1'b0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc  <= w_store_pc;
        r_req_exc <= w_fetch_exc;
        r_pc      <= w_fetch_pc + XLEN'(4);
      end
    end
  end

  assign w_wr_en          = r_req_valid & ~REDIRECT_VALID;
  assign w_wr_entry.pc    = r_req_pc;
  assign w_wr_entry.instr = IMEM_RDATA;
  assign w_wr_entry.exc   = r_req_exc;

  fetch_skid_buffer u_skid (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_wr_en   (w_wr_en),
    .i_rd_en   (w_deq),
    .i_flush   (REDIRECT_VALID),
    .i_wr_data (w_wr_entry),
    .o_count   (w_count),
    .o_head    (w_head)
  );

  assign IMEM_REQ  = w_issue & RESET_N;
  assign IMEM_ADDR = {2'b00, w_fetch_pc[XLEN-1:2]};
  assign IF_VALID  = w_if_valid;
  assign IF_PC     = w_head.pc;
  assign IF_INSTR  = w_head.exc ? INSTR_NOP : w_head.instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign IF_EXC    = w_head.exc;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: startup latency, backpressure, redirect,
// mid-stream reset, PC wrap and misaligned redirect (both macro settings).
module tb_instruction_fetch;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        IF_VALID;
  logic        ID_READY;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        IF_EXC;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  always #5 CLK = ~CLK;

  // Memory model: word at address A holds 0x100 + A.
  always @(posedge CLK) IMEM_RDATA <= 32'h100 + IMEM_ADDR;

  instruction_fetch dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_RDATA     (IMEM_RDATA),
    .IF_VALID       (IF_VALID),
    .ID_READY       (ID_READY),
    .IF_PC          (IF_PC),
    .IF_INSTR       (IF_INSTR)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .IF_EXC         (IF_EXC)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // n consecutive heads, each accepted on the following edge (ID_READY high).
  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk({tag, "_vld"}, 32'(IF_VALID), 32'h1);
      chk({tag, "_pc"}, IF_PC, exp_pc);
      chk({tag, "_instr"}, IF_INSTR, 32'h100 + (exp_pc >> 2));
      exp_pc = exp_pc + 32'h4;
    end
  endtask

  initial begin
    RESET_N        = 1'b0;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = 32'h0;
    ID_READY       = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_vld", 32'(IF_VALID), 32'h0);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_instr", IF_INSTR, 32'h0);
    chk("rst_req", 32'(IMEM_REQ), 32'h0);
    chk("rst_addr", IMEM_ADDR, 32'h0);

    // 1: startup, 2-cycle latency then one instruction per cycle
    RESET_N = 1'b1;
    #1;
    chk("t1_req", 32'(IMEM_REQ), 32'h1);
    chk("t1_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    chk("t1_lat", 32'(IF_VALID), 32'h0);
    exp_pc = 32'h0;
    stream("t1", 8);

    // 2: five cycles of backpressure
    @(negedge CLK);
    ID_READY = 1'b0;
    #1;
    chk("t2_req_drop", 32'(IMEM_REQ), 32'h0);
    chk("t2_hold_pc", IF_PC, exp_pc);
    repeat (4) begin
      @(negedge CLK);
      chk("t2_stall_vld", 32'(IF_VALID), 32'h1);
      chk("t2_stall_pc", IF_PC, exp_pc);
      chk("t2_stall_req", 32'(IMEM_REQ), 32'h0);
    end
    @(negedge CLK);
    ID_READY = 1'b1;
    #1;
    chk("t2_resume_req", 32'(IMEM_REQ), 32'h1);
    chk("t2_resume_pc", IF_PC, exp_pc);
    chk("t2_resume_instr", IF_INSTR, 32'h100 + (exp_pc >> 2));
    exp_pc = exp_pc + 32'h4;
    stream("t2", 6);

    // 3: redirect to 0x40 with a full buffer
    @(negedge CLK);
    ID_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t3_full_vld", 32'(IF_VALID), 32'h1);
    chk("t3_full_req", 32'(IMEM_REQ), 32'h0);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h40;
    ID_READY       = 1'b1;
    #1;
    chk("t3_addr", IMEM_ADDR, 32'h10);
    chk("t3_vld_forced", 32'(IF_VALID), 32'h0);
    chk("t3_req", 32'(IMEM_REQ), 32'h1);
    @(negedge CLK);
    REDIRECT_VALID = 1'b0;
    #1;
    chk("t3_gap", 32'(IF_VALID), 32'h0);
    exp_pc = 32'h40;
    stream("t3", 4);

    // 4: async reset with two entries buffered
    @(negedge CLK);
    ID_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t4_pre_vld", 32'(IF_VALID), 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t4_vld", 32'(IF_VALID), 32'h0);
    chk("t4_req", 32'(IMEM_REQ), 32'h0);
    chk("t4_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    RESET_N  = 1'b1;
    ID_READY = 1'b1;
    #1;
    chk("t4_restart_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    chk("t4_lat", 32'(IF_VALID), 32'h0);
    exp_pc = 32'h0;
    stream("t4", 3);

    // 5: PC wrap past the top of the address space
    @(negedge CLK);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFF8;
    #1;
    chk("t5_addr", IMEM_ADDR, 32'h3FFF_FFFE);
    @(negedge CLK);
    REDIRECT_VALID = 1'b0;
    #1;
    chk("t5_gap", 32'(IF_VALID), 32'h0);
    exp_pc = 32'hFFFF_FFF8;
    stream("t5", 3);

    // 6: misaligned redirect target
    @(negedge CLK);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h42;
    #1;
    chk("t6_addr", IMEM_ADDR, 32'h10);
    @(negedge CLK);
    REDIRECT_VALID = 1'b0;
    @(negedge CLK);
    chk("t6_vld0", 32'(IF_VALID), 32'h1);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t6_pc0", IF_PC, 32'h42);
    chk("t6_instr0", IF_INSTR, 32'h0000_0013);
    chk("t6_exc0", 32'(IF_EXC), 32'h1);
    @(negedge CLK);
    chk("t6_pc1", IF_PC, 32'h46);
    chk("t6_instr1", IF_INSTR, 32'h0000_0013);
    chk("t6_exc1", 32'(IF_EXC), 32'h1);
`else
    chk("t6_pc0", IF_PC, 32'h40);
    chk("t6_instr0", IF_INSTR, 32'h110);
    @(negedge CLK);
    chk("t6_pc1", IF_PC, 32'h44);
    chk("t6_instr1", IF_INSTR, 32'h111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
